// File: rtl/bias_add_requant_20_pkg.sv
// Layer-20 bias/requantization constants and shared types.
// Default parameter values for the bias-add/requant block and its sub-module.
package bias_add_requant_20_pkg;

    localparam int L20_KERN        = 16;
    localparam int L20_COEFF_WIDTH = 16;
    localparam int L20_ACC_WIDTH   = 32;
    localparam int L20_OUT_WIDTH   = 16;
    localparam int L20_BIAS_SHIFT  = 8;
    localparam int L20_SHIFT       = 8;
    localparam int L20_RELU        = 1;

    typedef enum logic {
        ST_LOAD,
        ST_RUN
    } state_t;

endpackage

// File: rtl/bias_add_requant_20_requant_sat.sv
// Combinational requantizer: round-half-up, arithmetic right shift,
// saturation to OUT_WIDTH and optional ReLU clip.
module bias_add_requant_20_requant_sat
    import bias_add_requant_20_pkg::*;
#(
    parameter int IN_WIDTH  = L20_ACC_WIDTH + 2,
    parameter int OUT_WIDTH = L20_OUT_WIDTH,
    parameter int SHIFT     = L20_SHIFT,
    parameter int RELU      = L20_RELU
) (
    input  logic signed [IN_WIDTH-1:0]  sum,
    output logic signed [OUT_WIDTH-1:0] result
);

    // One guard bit so adding the rounding constant can never wrap.
    localparam logic signed [IN_WIDTH:0] RND =
        (SHIFT > 0) ? ((IN_WIDTH + 1)'(1) << (SHIFT > 0 ? SHIFT - 1 : 0)) : '0;
    localparam logic signed [IN_WIDTH:0] MAX_V =
        {{(IN_WIDTH - OUT_WIDTH + 2){1'b0}}, {(OUT_WIDTH - 1){1'b1}}};
    localparam logic signed [IN_WIDTH:0] MIN_V =
        {{(IN_WIDTH - OUT_WIDTH + 2){1'b1}}, {(OUT_WIDTH - 1){1'b0}}};

    logic signed [IN_WIDTH:0] rounded;
    logic signed [IN_WIDTH:0] shifted;

    always_comb begin
        rounded = $signed({sum[IN_WIDTH-1], sum}) + RND;
        shifted = rounded >>> SHIFT;
        if (shifted > MAX_V) begin
            result = MAX_V[OUT_WIDTH-1:0];
        end else if (shifted < MIN_V) begin
            result = MIN_V[OUT_WIDTH-1:0];
        end else begin
            result = shifted[OUT_WIDTH-1:0];
        end
        if (RELU != 0 && shifted[IN_WIDTH]) begin
            result = '0;
        end
    end

endmodule

// File: rtl/bias_add_requant_20.sv
// Layer-20 bias add + requantization: loads KERN biases after reset, then adds the
// per-channel bias to each accumulator word and writes the requantized result.
module bias_add_requant_20
    import bias_add_requant_20_pkg::*;
#(
    parameter int KERN        = L20_KERN,
    parameter int COEFF_WIDTH = L20_COEFF_WIDTH,
    parameter int ACC_WIDTH   = L20_ACC_WIDTH,
    parameter int OUT_WIDTH   = L20_OUT_WIDTH,
    parameter int BIAS_SHIFT  = L20_BIAS_SHIFT,
    parameter int SHIFT       = L20_SHIFT,
    parameter int RELU        = L20_RELU
) (
    input  logic                   ap_clk,
    input  logic                   ap_rst,
    input  logic [COEFF_WIDTH-1:0] bias_V_dout,
    input  logic                   bias_V_empty_n,
    output logic                   bias_V_read,
    input  logic [ACC_WIDTH-1:0]   input_V_dout,
    input  logic                   input_V_empty_n,
    output logic                   input_V_read,
    output logic [OUT_WIDTH-1:0]   output_V_din,
    input  logic                   output_V_full_n,
    output logic                   output_V_write
);

    localparam int SUM_WIDTH = ACC_WIDTH + 2;
    localparam int IDX_WIDTH = (KERN > 1) ? $clog2(KERN) : 1;
    localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(KERN - 1);

    state_t                         state;
    state_t                         state_next;
    logic [IDX_WIDTH-1:0]           idx;
    logic [IDX_WIDTH-1:0]           ch;
    logic signed [COEFF_WIDTH-1:0]  bias_mem [KERN];
    logic signed [SUM_WIDTH-1:0]    s1;
    logic signed [SUM_WIDTH-1:0]    sum_next;
    logic signed [OUT_WIDTH-1:0]    result;
    logic [OUT_WIDTH-1:0]           s2;
    logic                           v1;
    logic                           v2;
    logic                           rst_q;
    logic                           quiet;
    logic                           en;
    logic                           bias_take;
    logic                           in_take;

    // Outputs stay silent during the reset cycle and the one after it.
    assign quiet = ap_rst | rst_q;

    always_comb begin
        // NOTE: defaults first so no path through this block infers a latch.
        state_next = state;
        bias_take  = 1'b0;
        if (state == ST_LOAD) begin
            bias_take = bias_V_empty_n & ~quiet;
            if (bias_take && idx == LAST_IDX) begin
                state_next = ST_RUN;
            end
        end
    end

    assign en       = ~v2 | output_V_full_n;
    assign in_take  = (state == ST_RUN) & input_V_empty_n & en & ~quiet;
    assign sum_next = SUM_WIDTH'($signed(input_V_dout))
                    + (SUM_WIDTH'(bias_mem[ch]) <<< BIAS_SHIFT);

    always_ff @(posedge ap_clk) begin
        // NOTE: non-blocking assignments for all state so every register sees pre-edge values.
        if (ap_rst) begin
            state <= ST_LOAD;
            idx   <= '0;
            ch    <= '0;
            s1    <= '0;
            s2    <= '0;
            v1    <= 1'b0;
            v2    <= 1'b0;
            rst_q <= 1'b1;
        end else begin
            rst_q <= 1'b0;
            state <= state_next;
            if (bias_take) begin
                idx <= idx + IDX_WIDTH'(1);
            end
            if (in_take) begin
                ch <= (ch == LAST_IDX) ? '0 : ch + IDX_WIDTH'(1);
            end
            if (en) begin
                v1 <= in_take;
                if (in_take) begin
                    s1 <= sum_next;
                end
                v2 <= v1;
                s2 <= result;
            end
        end
    end

    // NOTE: the bias bank has no reset; LOAD rewrites every entry before RUN reads any.
    always_ff @(posedge ap_clk) begin
        if (bias_take) begin
            bias_mem[idx] <= bias_V_dout;
        end
    end

    bias_add_requant_20_requant_sat #(
        .IN_WIDTH  (SUM_WIDTH),
        .OUT_WIDTH (OUT_WIDTH),
        .SHIFT     (SHIFT),
        .RELU      (RELU)
    ) u_requant_sat (
        .sum    (s1),
        .result (result)
    );

    assign bias_V_read    = bias_take;
    assign input_V_read   = in_take;
    assign output_V_write = v2 & output_V_full_n & ~quiet;
    assign output_V_din   = quiet ? '0 : s2;

endmodule

// File: tb/tb_bias_add_requant_20.sv
// Scoreboard bench for bias_add_requant_20: a ReLU and a non-ReLU instance share
// the same bias/accumulator FIFO models; expected words come from an arithmetic model.
module tb_bias_add_requant_20;

    localparam int KERN = 4;
    localparam int CW   = 16;
    localparam int AW   = 32;
    localparam int OW   = 16;
    localparam int BS   = 8;
    localparam int SH   = 8;
    localparam longint DIV   = 256;
    localparam longint HALF  = 128;
    localparam longint SCALE = 256;
    localparam longint MAXO  = 32767;
    localparam longint MINO  = -32768;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [CW-1:0] bias_dout = '0;
    logic          bias_empty_n = 1'b0;
    logic [AW-1:0] in_dout = '0;
    logic          in_empty_n = 1'b0;
    logic          full_n = 1'b0;
    logic          bias_read_a, bias_read_b, in_read_a, in_read_b, write_a, write_b;
    logic [OW-1:0] din_a, din_b;

    logic [CW-1:0] bias_q[$];
    logic [AW-1:0] in_q[$];
    logic [OW-1:0] exp_a[$];
    logic [OW-1:0] exp_b[$];
    int            rd_cyc_q[$];

    logic signed [CW-1:0] mbias [KERN];
    int  mch = 0;
    int  nb = 0;
    int  bias_pct = 100, in_pct = 100, full_pct = 100;
    bit  full_force_low = 1'b0;
    bit  take_bias = 1'b0, take_in = 1'b0;
    bit  rst_prev = 1'b0;
    int  cyc = 0, last_low = -1;
    int  bias_cnt = 0, rd_cnt = 0, wr_cnt = 0;
    int  n_cmp = 0, n_fail = 0;

    always #5 clk = ~clk;

    bias_add_requant_20 #(
        .KERN(KERN), .COEFF_WIDTH(CW), .ACC_WIDTH(AW), .OUT_WIDTH(OW),
        .BIAS_SHIFT(BS), .SHIFT(SH), .RELU(1)
    ) dut_a (
        .ap_clk(clk), .ap_rst(rst),
        .bias_V_dout(bias_dout), .bias_V_empty_n(bias_empty_n), .bias_V_read(bias_read_a),
        .input_V_dout(in_dout), .input_V_empty_n(in_empty_n), .input_V_read(in_read_a),
        .output_V_din(din_a), .output_V_full_n(full_n), .output_V_write(write_a)
    );

    bias_add_requant_20 #(
        .KERN(KERN), .COEFF_WIDTH(CW), .ACC_WIDTH(AW), .OUT_WIDTH(OW),
        .BIAS_SHIFT(BS), .SHIFT(SH), .RELU(0)
    ) dut_b (
        .ap_clk(clk), .ap_rst(rst),
        .bias_V_dout(bias_dout), .bias_V_empty_n(bias_empty_n), .bias_V_read(bias_read_b),
        .input_V_dout(in_dout), .input_V_empty_n(in_empty_n), .input_V_read(in_read_b),
        .output_V_din(din_b), .output_V_full_n(full_n), .output_V_write(write_b)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // Reference: exact integer sum, floor((sum + 2^(SH-1)) / 2^SH), clamp, optional ReLU.
    function automatic logic [OW-1:0] model(input logic [AW-1:0] acc,
                                            input logic signed [CW-1:0] b, input bit relu);
        longint s, t, r;
        s = longint'($signed(acc)) + longint'(b) * SCALE;
        t = s + HALF;
        if (t >= 0) r = t / DIV;
        else        r = -((-t + DIV - 1) / DIV);
        if (r > MAXO) r = MAXO;
        if (r < MINO) r = MINO;
        if (relu && r < 0) r = 0;
        return OW'(r);
    endfunction

    function automatic logic [AW-1:0] rand_acc();
        logic [31:0] rv;
        rv = $urandom();
        case ($urandom_range(3))
            0:       return rv;
            1:       return {{12{rv[19]}}, rv[19:0]};
            2:       return {{20{rv[11]}}, rv[11:0]};
            default: return (rv[0]) ? 32'h7FFF_FFFF : 32'h8000_0000;
        endcase
    endfunction

    // FIFO sources: pop what the DUT took last edge, then present the next head.
    always @(posedge clk) begin
        #1;
        if (take_bias && bias_q.size() > 0) void'(bias_q.pop_front());
        if (take_in && in_q.size() > 0) void'(in_q.pop_front());
        take_bias = 1'b0;
        take_in   = 1'b0;
        bias_dout    = (bias_q.size() > 0) ? bias_q[0] : '0;
        bias_empty_n = (bias_q.size() > 0) && ($urandom_range(99) < bias_pct);
        in_dout      = (in_q.size() > 0) ? in_q[0] : '0;
        in_empty_n   = (in_q.size() > 0) && ($urandom_range(99) < in_pct);
        full_n       = !full_force_low && ($urandom_range(99) < full_pct);
    end

    // Monitor: samples mid-cycle, compares against the scoreboard queues.
    always @(negedge clk) begin
        int rc;
        cyc++;
        if (rst || rst_prev) begin
            check("reset_quiet",
                  {bias_read_a, in_read_a, write_a, din_a, bias_read_b, in_read_b, write_b, din_b}, '0);
            bias_cnt = 0;
            rd_cnt   = 0;
            wr_cnt   = 0;
            rd_cyc_q.delete();
        end else begin
            if (bias_read_a | in_read_a | write_a | bias_read_b | in_read_b | write_b)
                check("lockstep", {bias_read_b, in_read_b, write_b}, {bias_read_a, in_read_a, write_a});
            if (bias_read_a) begin
                check("bias_read_after_load", bias_cnt < KERN, 1);
                bias_cnt++;
                take_bias = 1'b1;
            end
            if (in_read_a) begin
                check("input_read_before_load", bias_cnt >= KERN, 1);
                rd_cnt++;
                rd_cyc_q.push_back(cyc);
                take_in = 1'b1;
            end
            if (write_a) begin
                wr_cnt++;
                if (exp_a.size() == 0) check("unexpected_write_relu", 1, 0);
                else check("data_relu", din_a, exp_a.pop_front());
                if (rd_cyc_q.size() > 0) begin
                    rc = rd_cyc_q.pop_front();
                    if (last_low < rc) check("latency", cyc - rc, 2);
                    else check("latency_min", (cyc - rc) >= 2, 1);
                end
            end
            if (write_b) begin
                if (exp_b.size() == 0) check("unexpected_write_norelu", 1, 0);
                else check("data_norelu", din_b, exp_b.pop_front());
            end
            if (!full_n) begin
                check("held_le_2", (rd_cnt - wr_cnt) <= 2, 1);
                last_low = cyc;
            end
        end
        rst_prev = rst;
    end

    task automatic push_bias(input logic [CW-1:0] v);
        bias_q.push_back(v);
        if (nb < KERN) mbias[nb] = v;
        nb++;
    endtask

    task automatic push_word(input logic [AW-1:0] acc);
        in_q.push_back(acc);
        exp_a.push_back(model(acc, mbias[mch], 1'b1));
        exp_b.push_back(model(acc, mbias[mch], 1'b0));
        mch = (mch + 1) % KERN;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #3;
        rst = 1'b1;
        bias_q.delete();
        in_q.delete();
        exp_a.delete();
        exp_b.delete();
        mch = 0;
        nb  = 0;
        repeat (2) @(posedge clk);
        #3;
        rst = 1'b0;
    endtask

    task automatic wait_drain(input string tag);
        int n = 0;
        while ((exp_a.size() != 0 || exp_b.size() != 0) && n < 4000) begin
            @(posedge clk);
            n++;
        end
        #3;
        check({tag, "_drained"}, exp_a.size() + exp_b.size(), 0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #3;
        rst = 1'b0;

        // Load with gaps; inputs already waiting must not be read before the 4th bias.
        bias_pct = 40;
        push_bias(16'sd10);
        push_bias(-16'sd20);
        push_bias(16'sd0);
        push_bias(16'sd5);
        push_bias(16'sd77);
        push_word(32'd256);
        push_word(32'd0);
        push_word(32'h7FFF_FFFF);
        push_word(32'h8000_0000);
        wait_drain("directed");

        // Channel rotation over nine words.
        bias_pct = 100;
        for (int i = 0; i < 9; i++) push_word(rand_acc());
        wait_drain("stream9");

        // Backpressure window of five cycles in the middle of a stream.
        for (int i = 0; i < 12; i++) push_word(rand_acc());
        repeat (4) @(posedge clk);
        #3;
        full_force_low = 1'b1;
        repeat (5) @(posedge clk);
        #3;
        full_force_low = 1'b0;
        wait_drain("backpressure");

        // Reset after only two biases; the new set must be the one applied.
        do_reset();
        push_bias(16'($urandom()));
        push_bias(16'($urandom()));
        for (int i = 0; i < 4; i++) push_word(rand_acc());
        repeat (20) @(posedge clk);
        #3;
        check("partial_load_bias_cnt", bias_cnt, 2);
        check("partial_load_inputs_kept", in_q.size(), 4);
        do_reset();
        bias_pct = 50;
        for (int i = 0; i < KERN; i++) push_bias(16'($urandom()));
        for (int i = 0; i < 20; i++) push_word(rand_acc());
        wait_drain("reload");

        // Random handshakes, with a reset landing mid-RUN.
        in_pct   = 70;
        full_pct = 60;
        for (int i = 0; i < 150; i++) push_word(rand_acc());
        repeat (60) @(posedge clk);
        do_reset();
        for (int i = 0; i < KERN; i++) push_bias(16'($urandom()));
        for (int i = 0; i < 300; i++) push_word(rand_acc());
        wait_drain("random");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
